// File: rtl/ds18b20_temp_to_bcd_if.sv
// Sample/result bundle between a DS18B20 reader and the BCD converter.
// The master drives raw samples; the slave (converter) returns busy and BCD results.
interface ds18b20_temp_to_bcd_if;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        busy;
    logic        out_valid;
    logic        sign;
    logic [3:0]  bcd_hund;
    logic [3:0]  bcd_tens;
    logic [3:0]  bcd_ones;
    logic [3:0]  bcd_frac;
    logic        range_err;

    modport master (
        output temp_data, temp_valid,
        input  busy, out_valid, sign, bcd_hund, bcd_tens, bcd_ones, bcd_frac, range_err
    );

    modport slave (
        input  temp_data, temp_valid,
        output busy, out_valid, sign, bcd_hund, bcd_tens, bcd_ones, bcd_frac, range_err
    );
endinterface

// File: rtl/ds18b20_temp_to_bcd.sv
// DS18B20 raw temperature to sign + 3 integer BCD digits + 1 fraction digit (double dabble).
// Optional range flagging of samples outside -55..+125 degC: define DS18B20_RANGE_CHECK_EN.
module ds18b20_temp_to_bcd (
    input  logic                          sysclk,
    input  logic                          rst_n,
    ds18b20_temp_to_bcd_if.slave          bus
);
    typedef enum logic [1:0] {IDLE, PREP, SHIFT, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_raw_s;
    logic [10:0] r_raw_lo;
    logic        r_neg;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_frac;
    logic [2:0]  r_cnt;
    logic        r_out_valid;
    logic        r_sign;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic [3:0]  r_frac_out;
    logic [10:0] w_mag;
    logic [3:0]  w_frac;
    logic [11:0] w_adj;

`ifdef DS18B20_RANGE_CHECK_EN
    logic [3:0]  r_raw_mid;
    logic        r_oor;
    logic        r_range_err;
    logic [15:0] w_raw;
    logic        w_oor;

    assign w_raw = {r_raw_s, r_raw_mid, r_raw_lo};
    assign w_oor = ($signed(w_raw) > $signed(16'h07D0)) || ($signed(w_raw) < $signed(16'hFC90));
    assign bus.range_err = r_range_err;
`else
    assign bus.range_err = 1'b0;
`endif

    // Only the low 11 bits of the magnitude matter, and they negate independently of the upper bits.
    assign w_mag = r_raw_s ? (~r_raw_lo + 11'd1) : r_raw_lo;

    // (nibble * 10) >> 4, truncated
    always_comb begin
        w_frac = 4'd0;
        case (w_mag[3:0])
            4'd0, 4'd1:   w_frac = 4'd0;
            4'd2, 4'd3:   w_frac = 4'd1;
            4'd4:         w_frac = 4'd2;
            4'd5, 4'd6:   w_frac = 4'd3;
            4'd7:         w_frac = 4'd4;
            4'd8, 4'd9:   w_frac = 4'd5;
            4'd10, 4'd11: w_frac = 4'd6;
            4'd12:        w_frac = 4'd7;
            4'd13, 4'd14: w_frac = 4'd8;
            default:      w_frac = 4'd9;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                                : r_bcd[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.temp_valid) w_state_next = PREP;
            PREP:    w_state_next = SHIFT;
            SHIFT:   if (r_cnt == 3'd7) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_s     <= 1'b0;
            r_raw_lo    <= 11'd0;
            r_neg       <= 1'b0;
            r_bin       <= 8'd0;
            r_bcd       <= 12'd0;
            r_frac      <= 4'd0;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_hund      <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_frac_out  <= 4'd0;
`ifdef DS18B20_RANGE_CHECK_EN
            r_raw_mid   <= 4'd0;
            r_oor       <= 1'b0;
            r_range_err <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: if (bus.temp_valid) begin
                    r_raw_s  <= bus.temp_data[15];
                    r_raw_lo <= bus.temp_data[10:0];
`ifdef DS18B20_RANGE_CHECK_EN
                    r_raw_mid <= bus.temp_data[14:11];
`endif
                end
                PREP: begin
                    r_neg  <= r_raw_s;
                    r_bin  <= {1'b0, w_mag[10:4]};
                    r_bcd  <= 12'd0;
                    r_frac <= w_frac;
                    r_cnt  <= 3'd0;
`ifdef DS18B20_RANGE_CHECK_EN
                    r_oor  <= w_oor;
`endif
                end
                SHIFT: begin
                    r_bcd <= {w_adj[10:0], r_bin[7]};
                    r_bin <= {r_bin[6:0], 1'b0};
                    r_cnt <= r_cnt + 3'd1;
                end
                DONE: begin
                    r_out_valid <= 1'b1;
`ifdef DS18B20_RANGE_CHECK_EN
                    r_range_err <= r_oor;
                    if (!r_oor) begin
`else
                    begin
`endif
                        r_sign     <= r_neg;
                        r_hund     <= r_bcd[11:8];
                        r_tens     <= r_bcd[7:4];
                        r_ones     <= r_bcd[3:0];
                        r_frac_out <= r_frac;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.sign      = r_sign;
    assign bus.bcd_hund  = r_hund;
    assign bus.bcd_tens  = r_tens;
    assign bus.bcd_ones  = r_ones;
    assign bus.bcd_frac  = r_frac_out;
endmodule
